// File: rtl/wb_pkg.sv
// Shared types for the Wishbone burst initiator: FSM state encoding and
// the per-beat response flags captured when a bus beat completes.
package wb_pkg;

    localparam logic [1:0] WB_ST_IDLE  = 2'd0;
    localparam logic [1:0] WB_ST_WDATA = 2'd1;
    localparam logic [1:0] WB_ST_BUS   = 2'd2;
    localparam logic [1:0] WB_ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = WB_ST_IDLE,
        ST_WDATA = WB_ST_WDATA,
        ST_BUS   = WB_ST_BUS,
        ST_RESP  = WB_ST_RESP
    } wb_state_e;

    // Response status held alongside the captured data word.
    typedef struct packed {
        logic err;
        logic last;
    } wb_beat_flags_t;

    function automatic logic beat_is_last(input logic err, input logic at_len);
        return err | at_len;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Beat watchdog: down-counter loaded on entry to a bus wait, terminal at zero.
module wb_timeout_cnt
    import wb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             clr,
    output logic             terminal
);

    logic [WIDTH-1:0] cnt;

    assign terminal = (cnt == '0);

    // Load wins over clear so a wait can be armed straight out of idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !terminal) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone classic-cycle initiator: turns commands plus a write-data stream
// into incrementing-address beats and returns one response per beat.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WDATA | cyc held, waiting for the next write word
// BUS   | cyc+stb driven, waiting for ack, err or timeout
// RESP  | presenting the beat response, stb low
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_we,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [DATA_WIDTH-1:0]   wr_dat,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_err,
    output logic                    rsp_last,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    wb_cyc_o
);

    wb_state_e state, state_next;

    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    we_q;
    logic [SELECT_WIDTH-1:0] sel_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_q;
    logic [DATA_WIDTH-1:0]   wdat_q;
    logic [DATA_WIDTH-1:0]   rdat_q;
    wb_beat_flags_t          flags_q;

    logic cmd_fire;
    logic wr_fire;
    logic rsp_fire;
    logic bus_done;
    logic beat_err;
    logic timeout_hit;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign wr_fire  = wr_valid & wr_ready;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign bus_done = (state == ST_BUS) & (wb_err_i | wb_ack_i | timeout_hit);
    // err beats ack; a timeout only counts if the responder stayed silent.
    assign beat_err = wb_err_i | (~wb_ack_i & timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rsp_valid  = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    state_next = cmd_we ? ST_WDATA : ST_BUS;
                end
            end
            ST_WDATA: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                wb_cyc_o = 1'b1;
                if (wr_valid) begin
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                busy     = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (wb_err_i || wb_ack_i || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                wb_cyc_o  = ~flags_q.last;
                if (rsp_ready) begin
                    if (flags_q.last) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = we_q ? ST_WDATA : ST_BUS;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            flags_q <= '0;
        end else begin
            if (cmd_fire) begin
                adr_q  <= cmd_addr;
                we_q   <= cmd_we;
                sel_q  <= cmd_sel;
                len_q  <= cmd_len;
                beat_q <= '0;
            end
            if (wr_fire) begin
                wdat_q <= wr_dat;
            end
            if (bus_done) begin
                rdat_q       <= (beat_err || we_q) ? '0 : wb_dat_i;
                flags_q.err  <= beat_err;
                flags_q.last <= beat_is_last(beat_err, beat_q == len_q);
            end
            if (rsp_fire && !flags_q.last) begin
                beat_q <= beat_q + LEN_WIDTH'(1);
                adr_q  <= adr_q + ADDR_WIDTH'(SELECT_WIDTH);
            end
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int TO_W = $clog2(TIMEOUT + 1);
            logic to_term;

            wb_timeout_cnt #(
                .WIDTH(TO_W)
            ) u_timeout (
                .clk     (clk),
                .rst     (rst),
                .load    ((state != ST_BUS) && (state_next == ST_BUS)),
                .load_val(TO_W'(TIMEOUT - 1)),
                .en      (state == ST_BUS),
                .clr     (state == ST_IDLE),
                .terminal(to_term)
            );

            assign timeout_hit = to_term & (state == ST_BUS);
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign wb_adr_o = adr_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = wdat_q;
    assign rsp_dat  = rdat_q;
    assign rsp_err  = flags_q.err;
    assign rsp_last = flags_q.last;

endmodule
